// File: rtl/la_capture_ctrl.sv
// Capture controller for the logic analyzer: decodes UART commands, arms the trigger,
// gates sampling and uploads the captured samples as a framed byte stream.
module la_capture_ctrl #(
  parameter int unsigned CH_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned RX_TIMEOUT = 2700000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_done,
  input  logic                 trig_hit,
  output logic [CH_WIDTH-1:0]  trig_mask,
  output logic [CH_WIDTH-1:0]  trig_pattern,
  output logic [1:0]           trig_type,
  output logic                 sampler_en,
  output logic                 buf_clear,
  output logic                 buf_wr_en,
  output logic                 buf_rd_en,
  input  logic [CH_WIDTH-1:0]  buf_rd_data,
  input  logic                 buf_full,
  input  logic [CNT_WIDTH-1:0] buf_count,
  output logic [31:0]          freq_div,
  output logic [31:0]          duty_high,
  output logic [31:0]          rate_div,
  output logic                 freq_upd,
  output logic                 duty_upd,
  output logic                 rate_upd,
  output logic [3:0]           state_out
);

  localparam int unsigned NB        = CH_WIDTH / 8;
  localparam int unsigned TRIG_LEN  = 2 * NB + 1;
  localparam int unsigned STG_BYTES = (TRIG_LEN > 4) ? TRIG_LEN : 4;
  localparam int unsigned STG_W     = 8 * STG_BYTES;
  localparam int unsigned TMR_W     = $clog2(RX_TIMEOUT + 1);
  localparam int unsigned HDR_N     = (CNT_WIDTH > 16) ? 4 : 3;

  localparam logic [7:0] OP_START = 8'h01;
  localparam logic [7:0] OP_STOP  = 8'h02;
  localparam logic [7:0] OP_TRIG  = 8'h05;
  localparam logic [7:0] OP_FREQ  = 8'h06;
  localparam logic [7:0] OP_RATE  = 8'h07;
  localparam logic [7:0] OP_DUTY  = 8'h08;
  localparam logic [7:0] OP_LEN   = 8'h09;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RX_PAY   = 4'd1,
    S_ARM      = 4'd2,
    S_SAMPLING = 4'd3,
    S_TX_HDR   = 4'd4,
    S_TX_FETCH = 4'd5,
    S_TX_BYTE  = 4'd6,
    S_TX_WAIT  = 4'd7
  } state_t;

  state_t               state_q, ret_q;
  logic [7:0]           op_q;
  logic [3:0]           pay_len_q, pay_idx_q;
  logic [STG_W-1:0]     stage_q, stage_d;
  logic [TMR_W-1:0]     tmr_q;
  logic                 arm_first_q, hdr_phase_q, fetch_wait_q, abort_q;
  logic [1:0]           hdr_idx_q;
  logic [2:0]           byte_left_q;
  logic [CNT_WIDTH-1:0] samp_left_q, capture_len_q;
  logic [23:0]          total_q;
  logic [CH_WIDTH-1:0]  shreg_q, trig_mask_q, trig_pattern_q;
  logic [1:0]           trig_type_q;
  logic [31:0]          freq_div_q, duty_high_q, rate_div_q;
  logic [7:0]           tx_data_q;
  logic                 tx_start_q, sampler_en_q, buf_clear_q, buf_rd_en_q;
  logic                 freq_upd_q, duty_upd_q, rate_upd_q;

  logic       rx_start_c, rx_stop_c, gen_op_c, end_c, trig_ok_c, in_tx_c;
  logic [3:0] pay_len_c;
  logic [7:0] hdr_byte_c;

  assign rx_start_c = rx_valid && (rx_data == OP_START);
  assign rx_stop_c  = rx_valid && (rx_data == OP_STOP);
  assign gen_op_c   = rx_valid && ((rx_data == OP_FREQ) || (rx_data == OP_RATE) ||
                                   (rx_data == OP_DUTY));
  assign end_c      = buf_full || (buf_count >= capture_len_q);
  assign trig_ok_c  = (trig_type_q == 2'b00) || (trig_mask_q == '0) || trig_hit;
  assign in_tx_c    = (state_q == S_TX_HDR) || (state_q == S_TX_FETCH) ||
                      (state_q == S_TX_BYTE) || (state_q == S_TX_WAIT);

  // Payload length of the opcode currently on rx_data; zero means no payload
  always_comb begin
    pay_len_c = 4'd0;
    case (rx_data)
      OP_TRIG:                   pay_len_c = 4'(TRIG_LEN);
      OP_FREQ, OP_RATE, OP_DUTY: pay_len_c = 4'd4;
      OP_LEN:                    pay_len_c = 4'd3;
      default:                   pay_len_c = 4'd0;
    endcase
  end

  // Staging register with the incoming payload byte merged in
  always_comb begin
    stage_d = stage_q;
    for (int unsigned k = 0; k < STG_BYTES; k++) begin
      if (pay_idx_q == 4'(k)) stage_d[8*k +: 8] = rx_data;
    end
  end

  always_comb begin
    case (hdr_idx_q)
      2'd0:    hdr_byte_c = 8'hA5;
      2'd1:    hdr_byte_c = total_q[7:0];
      2'd2:    hdr_byte_c = total_q[15:8];
      default: hdr_byte_c = total_q[23:16];
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      ret_q          <= S_IDLE;
      op_q           <= '0;
      pay_len_q      <= '0;
      pay_idx_q      <= '0;
      stage_q        <= '0;
      tmr_q          <= '0;
      arm_first_q    <= 1'b0;
      hdr_phase_q    <= 1'b0;
      fetch_wait_q   <= 1'b0;
      abort_q        <= 1'b0;
      hdr_idx_q      <= '0;
      byte_left_q    <= '0;
      samp_left_q    <= '0;
      capture_len_q  <= '1;
      total_q        <= '0;
      shreg_q        <= '0;
      trig_mask_q    <= '1;
      trig_pattern_q <= '0;
      trig_type_q    <= 2'b00;
      freq_div_q     <= 32'd1350;
      duty_high_q    <= 32'd675;
      rate_div_q     <= 32'd270;
      tx_data_q      <= '0;
      tx_start_q     <= 1'b0;
      sampler_en_q   <= 1'b0;
      buf_clear_q    <= 1'b0;
      buf_rd_en_q    <= 1'b0;
      freq_upd_q     <= 1'b0;
      duty_upd_q     <= 1'b0;
      rate_upd_q     <= 1'b0;
    end else begin
      tx_start_q  <= 1'b0;
      buf_clear_q <= 1'b0;
      buf_rd_en_q <= 1'b0;
      freq_upd_q  <= 1'b0;
      duty_upd_q  <= 1'b0;
      rate_upd_q  <= 1'b0;
      // A STOP during upload lets the byte in flight finish, then abandons the frame
      if (in_tx_c && rx_stop_c) abort_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (rx_start_c) begin
            state_q     <= S_ARM;
            buf_clear_q <= 1'b1;
            arm_first_q <= 1'b1;
          end else if (rx_valid && (pay_len_c != 4'd0)) begin
            state_q   <= S_RX_PAY;
            ret_q     <= S_IDLE;
            op_q      <= rx_data;
            pay_len_q <= pay_len_c;
            pay_idx_q <= '0;
            stage_q   <= '0;
            tmr_q     <= '0;
          end
        end

        S_RX_PAY: begin
          if (rx_valid) begin
            tmr_q     <= '0;
            stage_q   <= stage_d;
            pay_idx_q <= pay_idx_q + 4'd1;
            if (pay_idx_q == pay_len_q - 4'd1) begin
              state_q <= ret_q;
              case (op_q)
                OP_TRIG: begin
                  trig_mask_q    <= stage_d[CH_WIDTH-1:0];
                  trig_pattern_q <= stage_d[2*CH_WIDTH-1:CH_WIDTH];
                  trig_type_q    <= stage_d[2*CH_WIDTH +: 2];
                end
                OP_FREQ: begin freq_div_q  <= stage_d[31:0]; freq_upd_q <= 1'b1; end
                OP_DUTY: begin duty_high_q <= stage_d[31:0]; duty_upd_q <= 1'b1; end
                OP_RATE: begin rate_div_q  <= stage_d[31:0]; rate_upd_q <= 1'b1; end
                OP_LEN:  capture_len_q <= stage_d[CNT_WIDTH-1:0];
                default: ;
              endcase
            end
          end else if (tmr_q == TMR_W'(RX_TIMEOUT - 1)) begin
            state_q      <= S_IDLE;
            sampler_en_q <= 1'b0;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end

        S_ARM: begin
          arm_first_q <= 1'b0;
          if (rx_stop_c) begin
            state_q <= S_IDLE;
          end else if (gen_op_c) begin
            state_q   <= S_RX_PAY;
            ret_q     <= S_ARM;
            op_q      <= rx_data;
            pay_len_q <= pay_len_c;
            pay_idx_q <= '0;
            stage_q   <= '0;
            tmr_q     <= '0;
          end else if (!arm_first_q && trig_ok_c) begin
            state_q      <= S_SAMPLING;
            sampler_en_q <= 1'b1;
          end
        end

        S_SAMPLING: begin
          if (rx_stop_c || end_c) begin
            state_q      <= S_TX_HDR;
            sampler_en_q <= 1'b0;
            total_q      <= 24'(buf_count);
            samp_left_q  <= buf_count;
            hdr_idx_q    <= '0;
            hdr_phase_q  <= 1'b1;
            abort_q      <= 1'b0;
          end else if (gen_op_c) begin
            state_q   <= S_RX_PAY;
            ret_q     <= S_SAMPLING;
            op_q      <= rx_data;
            pay_len_q <= pay_len_c;
            pay_idx_q <= '0;
            stage_q   <= '0;
            tmr_q     <= '0;
          end
        end

        S_TX_HDR: begin
          tx_data_q  <= hdr_byte_c;
          tx_start_q <= 1'b1;
          state_q    <= S_TX_WAIT;
        end

        // Read request goes out in the first cycle; data is captured in the second
        S_TX_FETCH: begin
          if (abort_q || rx_stop_c) begin
            state_q <= S_IDLE;
          end else if (fetch_wait_q) begin
            fetch_wait_q <= 1'b0;
          end else begin
            shreg_q     <= buf_rd_data;
            byte_left_q <= 3'(NB);
            state_q     <= S_TX_BYTE;
          end
        end

        S_TX_BYTE: begin
          tx_data_q   <= shreg_q[7:0];
          tx_start_q  <= 1'b1;
          shreg_q     <= shreg_q >> 8;
          byte_left_q <= byte_left_q - 3'd1;
          state_q     <= S_TX_WAIT;
        end

        S_TX_WAIT: begin
          if (tx_done) begin
            if (abort_q || rx_stop_c) begin
              state_q <= S_IDLE;
            end else if (hdr_phase_q) begin
              if (hdr_idx_q == 2'(HDR_N - 1)) begin
                hdr_phase_q <= 1'b0;
                if (samp_left_q == '0) begin
                  state_q <= S_IDLE;
                end else begin
                  state_q      <= S_TX_FETCH;
                  samp_left_q  <= samp_left_q - CNT_WIDTH'(1);
                  buf_rd_en_q  <= 1'b1;
                  fetch_wait_q <= 1'b1;
                end
              end else begin
                hdr_idx_q <= hdr_idx_q + 2'd1;
                state_q   <= S_TX_HDR;
              end
            end else if (byte_left_q != 3'd0) begin
              state_q <= S_TX_BYTE;
            end else if (samp_left_q != '0) begin
              state_q      <= S_TX_FETCH;
              samp_left_q  <= samp_left_q - CNT_WIDTH'(1);
              buf_rd_en_q  <= 1'b1;
              fetch_wait_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign trig_mask    = trig_mask_q;
  assign trig_pattern = trig_pattern_q;
  assign trig_type    = trig_type_q;
  assign sampler_en   = sampler_en_q;
  assign buf_clear    = buf_clear_q;
  assign buf_wr_en    = sampler_en_q && !buf_full;
  assign buf_rd_en    = buf_rd_en_q;
  assign freq_div     = freq_div_q;
  assign duty_high    = duty_high_q;
  assign rate_div     = rate_div_q;
  assign freq_upd     = freq_upd_q;
  assign duty_upd     = duty_upd_q;
  assign rate_upd     = rate_upd_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl (16 channels): command table plus multi-cycle
// sequences for timeout, triggering, mid-capture settings and framed upload.
module tb_la_capture_ctrl;

  localparam int unsigned CH  = 16;
  localparam int unsigned CNT = 16;
  localparam int unsigned TMO = 40;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [7:0]     rx_data = '0;
  logic           rx_valid = 1'b0;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_done;
  logic           trig_hit = 1'b0;
  logic [CH-1:0]  trig_mask, trig_pattern;
  logic [1:0]     trig_type;
  logic           sampler_en, buf_clear, buf_wr_en, buf_rd_en;
  logic [CH-1:0]  buf_rd_data;
  logic           buf_full = 1'b0;
  logic [CNT-1:0] buf_count = '0;
  logic [31:0]    freq_div, duty_high, rate_div;
  logic           freq_upd, duty_upd, rate_upd;
  logic [3:0]     state_out;

  la_capture_ctrl #(.CH_WIDTH(CH), .CNT_WIDTH(CNT), .RX_TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done), .trig_hit(trig_hit),
    .trig_mask(trig_mask), .trig_pattern(trig_pattern), .trig_type(trig_type),
    .sampler_en(sampler_en), .buf_clear(buf_clear), .buf_wr_en(buf_wr_en),
    .buf_rd_en(buf_rd_en), .buf_rd_data(buf_rd_data), .buf_full(buf_full),
    .buf_count(buf_count), .freq_div(freq_div), .duty_high(duty_high),
    .rate_div(rate_div), .freq_upd(freq_upd), .duty_upd(duty_upd),
    .rate_upd(rate_upd), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // UART transmitter, sample buffer and strobe monitors
  logic [7:0]  txq[$];
  logic [15:0] mem [0:7];
  int tx_cd;
  int rd_ptr;
  int fu_cnt = 0, du_cnt = 0, ru_cnt = 0, clr_cnt = 0, multi_err = 0, drop_cnt = 0;
  bit watch_en = 1'b0;

  always @(posedge clk) begin
    if (!resetn) begin
      tx_done     <= 1'b0;
      tx_cd       <= 0;
      rd_ptr      <= 0;
      buf_rd_data <= '0;
    end else begin
      tx_done <= 1'b0;
      if (tx_start) begin
        txq.push_back(tx_data);
        tx_cd <= 4;
      end else if (tx_cd > 0) begin
        if (tx_cd == 1) tx_done <= 1'b1;
        tx_cd <= tx_cd - 1;
      end
      if (buf_clear) rd_ptr <= 0;
      else if (buf_rd_en) begin
        buf_rd_data <= mem[rd_ptr[2:0]];
        rd_ptr      <= rd_ptr + 1;
      end
    end
    if (freq_upd)  fu_cnt  <= fu_cnt + 1;
    if (duty_upd)  du_cnt  <= du_cnt + 1;
    if (rate_upd)  ru_cnt  <= ru_cnt + 1;
    if (buf_clear) clr_cnt <= clr_cnt + 1;
    if ((32'(freq_upd) + 32'(duty_upd) + 32'(rate_upd)) > 32'd1) multi_err <= multi_err + 1;
    if (watch_en && !sampler_en) drop_cnt <= drop_cnt + 1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string nm);
    int n;
    n = 0;
    while (state_out !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(state_out), 32'(s));
  endtask

  typedef struct {
    int          n;
    logic [63:0] bytes;   // byte k at [8k+7:8k]
    logic [31:0] e_freq, e_duty, e_rate;
    logic [15:0] e_mask, e_pat;
    logic [1:0]  e_type;
    int          e_fu, e_du, e_ru;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish before 1000000");
    $fatal(1);
  end

  initial begin
    int f0, d0, r0, c0, base;
    logic [7:0] exp_f [9];
    logic [7:0] exp_g [3];

    vecs[0] = '{5, 64'h000000000F424006, 32'h000F4240, 32'd675,   32'd270,      16'hFFFF, 16'h0000, 2'd0, 1, 0, 0};
    vecs[1] = '{5, 64'h0000000000271008, 32'h000F4240, 32'd10000, 32'd270,      16'hFFFF, 16'h0000, 2'd0, 0, 1, 0};
    vecs[2] = '{5, 64'h0000001234567807, 32'h000F4240, 32'd10000, 32'h12345678, 16'hFFFF, 16'h0000, 2'd0, 0, 0, 1};
    vecs[3] = '{6, 64'h000001005000F005, 32'h000F4240, 32'd10000, 32'h12345678, 16'h00F0, 16'h0050, 2'd1, 0, 0, 0};
    vecs[4] = '{1, 64'h0000000000000033, 32'h000F4240, 32'd10000, 32'h12345678, 16'h00F0, 16'h0050, 2'd1, 0, 0, 0};
    vecs[5] = '{1, 64'h0000000000000002, 32'h000F4240, 32'd10000, 32'h12345678, 16'h00F0, 16'h0050, 2'd1, 0, 0, 0};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_freq",  freq_div,  32'd1350);
    chk("rst_duty",  duty_high, 32'd675);
    chk("rst_rate",  rate_div,  32'd270);
    chk("rst_mask",  32'(trig_mask), 32'h0000FFFF);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_txs",   32'(tx_start), 32'd0);
    chk("rst_txd",   32'(tx_data), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Command table
    for (int i = 0; i < 6; i++) begin
      f0 = fu_cnt; d0 = du_cnt; r0 = ru_cnt;
      for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].bytes[8*k +: 8]);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_freq", i),  freq_div,  vecs[i].e_freq);
      chk($sformatf("v%0d_duty", i),  duty_high, vecs[i].e_duty);
      chk($sformatf("v%0d_rate", i),  rate_div,  vecs[i].e_rate);
      chk($sformatf("v%0d_mask", i),  32'(trig_mask),    32'(vecs[i].e_mask));
      chk($sformatf("v%0d_pat", i),   32'(trig_pattern), 32'(vecs[i].e_pat));
      chk($sformatf("v%0d_type", i),  32'(trig_type),    32'(vecs[i].e_type));
      chk($sformatf("v%0d_state", i), 32'(state_out), 32'd0);
      chk($sformatf("v%0d_fupd", i),  32'(fu_cnt - f0), 32'(vecs[i].e_fu));
      chk($sformatf("v%0d_dupd", i),  32'(du_cnt - d0), 32'(vecs[i].e_du));
      chk($sformatf("v%0d_rupd", i),  32'(ru_cnt - r0), 32'(vecs[i].e_ru));
    end

    // Payload timeout discards staged bytes
    f0 = fu_cnt;
    send_byte(8'h06); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    chk("tmo_in_pay", 32'(state_out), 32'd1);
    repeat (TMO + 5) @(negedge clk);
    chk("tmo_state", 32'(state_out), 32'd0);
    chk("tmo_freq",  freq_div, 32'h000F4240);
    chk("tmo_fupd",  32'(fu_cnt - f0), 32'd0);

    // Rising-edge trigger waits in ARM until trig_hit
    c0 = clr_cnt;
    send_byte(8'h01);
    repeat (1000) @(negedge clk);
    chk("arm_hold",   32'(state_out), 32'd2);
    chk("arm_samp",   32'(sampler_en), 32'd0);
    chk("arm_clr",    32'(clr_cnt - c0), 32'd1);
    trig_hit = 1'b1;
    @(negedge clk);
    trig_hit = 1'b0;
    chk("trig_state", 32'(state_out), 32'd3);
    chk("trig_samp",  32'(sampler_en), 32'd1);

    // Rate update mid-capture keeps sampling running
    r0 = ru_cnt;
    watch_en = 1'b1;
    send_byte(8'h07); send_byte(8'h0E); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    repeat (2) @(negedge clk);
    watch_en = 1'b0;
    chk("midcap_rate",  rate_div, 32'd270);
    chk("midcap_rupd",  32'(ru_cnt - r0), 32'd1);
    chk("midcap_state", 32'(state_out), 32'd3);
    chk("midcap_drop",  32'(drop_cnt), 32'd0);
    chk("midcap_wr",    32'(buf_wr_en), 32'd1);

    // buf_full and STOP together: one transition, then STOP aborts the upload
    base = txq.size();
    @(negedge clk);
    buf_count = 16'd7;
    buf_full  = 1'b1;
    rx_data   = 8'h02;
    rx_valid  = 1'b1;
    #1;
    chk("full_wr", 32'(buf_wr_en), 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    buf_full = 1'b0;
    chk("full_state", 32'(state_out), 32'd4);
    chk("full_samp",  32'(sampler_en), 32'd0);
    for (int n = 0; n < 100 && txq.size() < base + 2; n++) @(negedge clk);
    chk("abort_seen2", 32'(txq.size() - base), 32'd2);
    send_byte(8'h02);
    wait_state(4'd0, 50, "abort_idle");
    repeat (10) @(negedge clk);
    chk("abort_nbytes", 32'(txq.size() - base), 32'd2);
    if (txq.size() >= base + 2) begin
      chk("abort_b0", 32'(txq[base]),     32'hA5);
      chk("abort_b1", 32'(txq[base + 1]), 32'h07);
    end
    buf_count = '0;

    // STOP in ARM returns to IDLE with no upload
    base = txq.size();
    send_byte(8'h01);
    repeat (3) @(negedge clk);
    chk("stoparm_arm", 32'(state_out), 32'd2);
    send_byte(8'h02);
    repeat (20) @(negedge clk);
    chk("stoparm_idle", 32'(state_out), 32'd0);
    chk("stoparm_notx", 32'(txq.size() - base), 32'd0);

    // Length-limited capture and full framed upload
    send_byte(8'h09); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h05); send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("imm_type", 32'(trig_type), 32'd0);
    mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0001;
    exp_f = '{8'hA5, 8'h03, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00};
    base = txq.size();
    c0 = clr_cnt;
    send_byte(8'h01);
    wait_state(4'd3, 20, "upl_samp");
    buf_count = 16'd3;
    wait_state(4'd0, 500, "upl_idle");
    repeat (5) @(negedge clk);
    chk("upl_clr",    32'(clr_cnt - c0), 32'd1);
    chk("upl_nbytes", 32'(txq.size() - base), 32'd9);
    for (int k = 0; k < 9; k++) begin
      if (base + k < txq.size()) chk($sformatf("upl_b%0d", k), 32'(txq[base + k]), 32'(exp_f[k]));
    end

    // Zero-length capture sends only the header
    buf_count = '0;
    exp_g = '{8'hA5, 8'h00, 8'h00};
    base = txq.size();
    send_byte(8'h01);
    wait_state(4'd3, 20, "zero_samp");
    send_byte(8'h02);
    wait_state(4'd0, 200, "zero_idle");
    repeat (10) @(negedge clk);
    chk("zero_nbytes", 32'(txq.size() - base), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (base + k < txq.size()) chk($sformatf("zero_b%0d", k), 32'(txq[base + k]), 32'(exp_g[k]));
    end

    chk("multi_upd", 32'(multi_err), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
